// File: rtl/alu_pkg.sv
// Shared op_func encodings and FSM state encoding for multicycle_alu.
// Latency: n/a (definitions only).
// Backpressure: n/a. The DIV state exists only when MULTICYCLE_ALU_DIV_EN is defined.
package alu_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b010000;
    localparam logic [5:0] OP_COMP  = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b010100;
    localparam logic [5:0] OP_XOR   = 6'b010101;
    localparam logic [5:0] OP_SLL   = 6'b000010;
    localparam logic [5:0] OP_SLLV  = 6'b010111;
    localparam logic [5:0] OP_SRL   = 6'b000011;
    localparam logic [5:0] OP_SRLV  = 6'b010110;
    localparam logic [5:0] OP_SRA   = 6'b000100;
    localparam logic [5:0] OP_SRAV  = 6'b011000;
    localparam logic [5:0] OP_MULU  = 6'b010001;
    localparam logic [5:0] OP_MULS  = 6'b010010;
    localparam logic [5:0] OP_DIVU  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MULTICYCLE_ALU_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier (and restoring divider under MULTICYCLE_ALU_DIV_EN), one bit per cycle.
// Latency: WIDTH cycles after start; done is high during the final iteration.
// Backpressure: none; the caller must not start while busy.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
`ifdef MULTICYCLE_ALU_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] low,
    output logic [WIDTH-1:0] high
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;
    logic               neg;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
`ifdef MULTICYCLE_ALU_DIV_EN
    logic               div_mode;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
`endif

    // Magnitudes are taken as unsigned so the most-negative operand needs no special case.
    assign a_abs = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_abs = (is_signed && b[WIDTH-1]) ? -b : b;

    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_next = {add_sum, acc[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIV_EN
        trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff  = trial - {1'b0, opnd};
        if (div_mode) begin
            acc_next = diff[WIDTH] ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
        end
`endif
    end

    assign done   = busy && (cnt == CW'(WIDTH - 1));
    assign result = neg ? -acc : acc;
    assign low    = result[WIDTH-1:0];
    assign high   = result[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            opnd <= '0;
            acc  <= '0;
            neg  <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_mode <= 1'b0;
`endif
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_mode <= is_div;
            if (is_div) begin
                opnd <= b;
                acc  <= {{WIDTH{1'b0}}, a};
                neg  <= 1'b0;
            end else begin
                opnd <= a_abs;
                acc  <= {{WIDTH{1'b0}}, b_abs};
                neg  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            end
`else
            opnd <= a_abs;
            acc  <= {{WIDTH{1'b0}}, b_abs};
            neg  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
        end else if (busy) begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked execute-stage ALU; optional divu when MULTICYCLE_ALU_DIV_EN is defined.
// Latency: single-cycle ops 1 cycle; mul/div results WIDTH+1 edges after accept.
// Backpressure: result held while out_valid && !out_ready; in_ready low while busy or stalled.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op_code,
    input  logic [3:0]       func_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] low,
    output logic [WIDTH-1:0] high,
    output logic             flag_carry,
    output logic             flag_zero,
    output logic             flag_err
);

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    logic [5:0]       op_func;
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] sc_low;
    logic             sc_carry;
    logic             sc_err;
    logic             is_mul;
    logic             is_signed;
    logic             multi;
    logic             accept;
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_low;
    logic [WIDTH-1:0] md_high;
`ifdef MULTICYCLE_ALU_DIV_EN
    logic             is_div;
`endif

    assign op_func  = {op_code, func_code};
    assign sh       = b[SW-1:0];
    assign in_ready = (state == IDLE) && !md_busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && multi;

    always_comb begin
        sc_low    = '0;
        sc_carry  = 1'b0;
        sc_err    = 1'b0;
        is_mul    = 1'b0;
        is_signed = 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
        is_div    = 1'b0;
`endif
        case (op_func)
            OP_ADD, OP_ADDI:   {sc_carry, sc_low} = {1'b0, a} + {1'b0, b};
            OP_COMP:           sc_low = -b;
            OP_AND:            sc_low = a & b;
            OP_XOR:            sc_low = a ^ b;
            OP_SLL, OP_SLLV:   sc_low = a << sh;
            OP_SRL, OP_SRLV:   sc_low = a >> sh;
            OP_SRA, OP_SRAV:   sc_low = $signed(a) >>> sh;
            OP_MULU:           is_mul = 1'b1;
            OP_MULS: begin
                is_mul    = 1'b1;
                is_signed = 1'b1;
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            OP_DIVU:           is_div = 1'b1;
`endif
            default:           sc_err = 1'b1;
        endcase
`ifdef MULTICYCLE_ALU_DIV_EN
        multi = is_mul || is_div;
`else
        multi = is_mul;
`endif
    end

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .is_signed (is_signed),
`ifdef MULTICYCLE_ALU_DIV_EN
        .is_div    (is_div),
`endif
        .a         (a),
        .b         (b),
        .busy      (md_busy),
        .done      (md_done),
        .low       (md_low),
        .high      (md_high)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            low        <= '0;
            high       <= '0;
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
            flag_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && multi) begin
                        out_valid <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
                        state     <= is_div ? DIV : MUL;
`else
                        state     <= MUL;
`endif
                    end else if (accept) begin
                        out_valid  <= 1'b1;
                        low        <= sc_low;
                        high       <= {WIDTH{sc_low[WIDTH-1]}};
                        flag_carry <= sc_carry;
                        flag_zero  <= (sc_low == '0);
                        flag_err   <= sc_err;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: if (md_done) state <= DONE;
`ifdef MULTICYCLE_ALU_DIV_EN
                DIV: if (md_done) state <= DONE;
`endif
                DONE: begin
                    out_valid  <= 1'b1;
                    low        <= md_low;
                    high       <= md_high;
                    flag_carry <= 1'b0;
                    flag_zero  <= (md_low == '0);
                    flag_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=32 with hand-computed expected values.
module tb_multicycle_alu;

    localparam logic [5:0] F_ADD  = 6'b000000;
    localparam logic [5:0] F_COMP = 6'b000001;
    localparam logic [5:0] F_AND  = 6'b010100;
    localparam logic [5:0] F_XOR  = 6'b010101;
    localparam logic [5:0] F_SLL  = 6'b010111;
    localparam logic [5:0] F_SRL  = 6'b000011;
    localparam logic [5:0] F_SRA  = 6'b011000;
    localparam logic [5:0] F_MULU = 6'b010001;
    localparam logic [5:0] F_MULS = 6'b010010;
    localparam logic [5:0] F_DIVU = 6'b010011;
    localparam logic [5:0] F_BAD  = 6'b111111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op_code = '0;
    logic [3:0]  func_code = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] low;
    logic [31:0] high;
    logic        flag_carry;
    logic        flag_zero;
    logic        flag_err;

    int n_chk  = 0;
    int n_pass = 0;
    int edges;
    int lo_cnt;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_code    (op_code),
        .func_code  (func_code),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .low        (low),
        .high       (high),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .flag_err   (flag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        op_code   = f[5:4];
        func_code = f[3:0];
        a         = x;
        b         = y;
        in_valid  = 1'b1;
    endtask

    // Issue one op, then count edges after the accepting edge until out_valid.
    task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        int waitc = 0;
        drive(f, x, y);
        #1;
        while (!in_ready && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("issue_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges  = 0;
        lo_cnt = 0;
        while (!out_valid && edges < 200) begin
            if (!in_ready) lo_cnt++;
            @(posedge clk); #1;
            edges++;
        end
        check("result_valid", {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_low_high", {high, low}, 64'd0);
        check("rst_flags", {61'd0, flag_carry, flag_zero, flag_err}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        run_op(F_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        check("add_latency", 64'(edges), 64'd0);
        check("add_result", {high, low}, 64'h0000_0000_0000_0000);
        check("add_flags", {61'd0, flag_carry, flag_zero, flag_err}, 64'b110);

        run_op(F_MULS, 32'hFFFF_FFFD, 32'h0000_0005);
        check("muls_busy_cycles", 64'(lo_cnt), 64'd33);
        check("muls_latency", 64'(edges), 64'd33);
        check("muls_result", {high, low}, 64'hFFFF_FFFF_FFFF_FFF1);

        run_op(F_MULU, 32'h8000_0000, 32'h0000_0002);
        check("mulu_result", {high, low}, 64'h0000_0001_0000_0000);
        check("mulu_zero", {63'd0, flag_zero}, 64'd1);

        run_op(F_MULS, 32'h8000_0000, 32'h8000_0000);
        check("muls_minneg", {high, low}, 64'h4000_0000_0000_0000);

        run_op(F_SRA, 32'h8000_0000, 32'h0000_0024);
        check("sra_result", {high, low}, 64'hFFFF_FFFF_F800_0000);
        run_op(F_SLL, 32'h0000_0001, 32'h0000_001F);
        check("sll_result", {high, low}, 64'hFFFF_FFFF_8000_0000);
        run_op(F_SRL, 32'h8000_0000, 32'h0000_0021);
        check("srl_result", {high, low}, 64'h0000_0000_4000_0000);
        run_op(F_COMP, 32'h0000_0000, 32'h0000_0005);
        check("comp_result", {high, low}, 64'hFFFF_FFFF_FFFF_FFFB);
        check("comp_flags", {61'd0, flag_carry, flag_zero, flag_err}, 64'b000);

        // Back-to-back single-cycle ops, one result per cycle.
        drive(F_ADD, 32'd1, 32'd2);
        @(posedge clk); #1;
        check("bb_add", {31'd0, out_valid, low}, {31'd0, 1'b1, 32'd3});
        check("bb_rdy1", {63'd0, in_ready}, 64'd1);
        drive(F_XOR, 32'hF0, 32'hFF);
        @(posedge clk); #1;
        check("bb_xor", {31'd0, out_valid, low}, {31'd0, 1'b1, 32'h0F});
        check("bb_rdy2", {63'd0, in_ready}, 64'd1);
        drive(F_AND, 32'hF0, 32'hFF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bb_and", {31'd0, out_valid, low}, {31'd0, 1'b1, 32'hF0});

        // Stall: result held, new op waits, then retire and accept together.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(F_ADD, 32'd10, 32'd20);
        @(posedge clk); #1;
        drive(F_XOR, 32'd3, 32'd5);
        for (int i = 0; i < 3; i++) begin
            check("stall_result", {30'd0, out_valid, flag_zero, low}, {30'd0, 2'b10, 32'd30});
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("release_next", {31'd0, out_valid, low}, {31'd0, 1'b1, 32'd6});

        // Reset in the middle of a multiply.
        drive(F_MULU, 32'd3, 32'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(F_ADD, 32'd2, 32'd3);
        check("post_abort_add", {high, low}, 64'd5);
        repeat (40) begin
            @(posedge clk); #1;
        end
        check("no_stale_mul", {31'd0, out_valid, low}, {31'd0, 1'b0, 32'd5});

`ifdef MULTICYCLE_ALU_DIV_EN
        run_op(F_DIVU, 32'd100, 32'd7);
        check("divu_latency", 64'(edges), 64'd33);
        check("divu_result", {high, low}, {32'd2, 32'd14});
        check("divu_err", {63'd0, flag_err}, 64'd0);
        run_op(F_DIVU, 32'd5, 32'd0);
        check("divu_by_zero", {high, low}, {32'd5, 32'hFFFF_FFFF});
        check("divu0_err", {63'd0, flag_err}, 64'd0);
`else
        run_op(F_DIVU, 32'd100, 32'd7);
        check("divu_illegal_lat", 64'(edges), 64'd0);
        check("divu_illegal", {31'd0, flag_err, low}, {31'd0, 1'b1, 32'd0});
        check("divu_illegal_hi", {32'd0, high}, 64'd0);
`endif
        run_op(F_BAD, 32'h1234_5678, 32'h9ABC_DEF0);
        check("illegal_op", {31'd0, flag_err, low}, {31'd0, 1'b1, 32'd0});
        check("illegal_hi", {32'd0, high}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
